flow_ctrl: RTL
==============

Name: flow_ctrl

Overview:
- Pipeline flow controller for the 5-stage core. It owns the N/Z/V flag register and resolves branches in EX using the team's 3-bit condition encoding.
- It drives the PC-select, stall and flush/bubble controls for IF, IF/ID and ID/EX.
- It sequences HLT: drain MEM/WB, then freeze the machine.
- It also keeps a saturating taken-branch counter for performance bring-up.

Parameters:
- PC_W, 16, width of PC and branch target
- DRAIN_CYCLES, 2, cycles after HLT leaves EX before halted asserts (MEM + WB)
- CNT_W, 16, width of taken-branch counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_opcode  in  4  opcode in EX; 4'b1100 = B, 4'b1111 = HLT
- ex_br_cond  in  3  branch condition field in EX
- ex_target  in  PC_W  branch target computed in EX
- ex_set_flags  in  1  EX instruction updates flags (ADD/SUB/etc.)
- alu_n, alu_z, alu_v  in  1 each  ALU flag results for the EX instruction
- id_ld_use  in  1  load-use hazard detected between ID and EX
- pc_sel  out  1  1 = next PC is pc_target
- pc_target  out  PC_W  redirect target
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID register
- flush_ifid  out  1  clear IF/ID to bubble
- bubble_idex  out  1  insert bubble into ID/EX
- flag_n, flag_z, flag_v  out  1 each  registered flags
- halted  out  1  processor frozen
- br_taken_cnt  out  CNT_W  count of taken branches

Behaviour:
- Reset (async, rst=1): flags=0, state=RUN, drain counter=0, halted=0, br_taken_cnt=0. All combinational outputs are 0 while in RUN with no stimulus.
- Condition codes are evaluated against the registered flags:
  - 000: Z==0
  - 001: Z==1
  - 010: Z==0 && N==0
  - 011: N==1
  - 100: N==0
  - 101: N==1 || Z==1
  - 110: V==1
  - 111: always
- Taken branch: taken = ex_valid && ex_opcode==B && cond true && state==RUN.
- Flags:
  - On the clock edge with ex_valid && ex_set_flags && state==RUN, flags <= {alu_n, alu_z, alu_v}.
  - A branch therefore sees the flags of the nearest older flag-setting instruction; no forwarding is needed because that instruction was in EX one or more cycles earlier.
  - A B instruction never writes flags.
- Redirect (same cycle, combinational): when taken, pc_sel=1, pc_target=ex_target, flush_ifid=1, bubble_idex=1. stall_pc and stall_ifid are 0 so the redirect wins over a hazard.
  - pc_target = ex_target at all times; it is only meaningful when pc_sel=1.
- Load-use: id_ld_use && !taken && state==RUN gives stall_pc=1, stall_ifid=1, bubble_idex=1. Stall lasts exactly as long as id_ld_use is high.
- Counter: br_taken_cnt increments on each cycle with taken=1 and saturates at all-ones (no wrap).
- State machine:
  - RUN -> DRAIN when ex_valid && ex_opcode==HLT; load drain counter with DRAIN_CYCLES-1.
  - DRAIN: stall_pc=1, flush_ifid=1, bubble_idex=1. Counter decrements each cycle; at 0 go to HALT.
  - HALT: halted=1, stall_pc=1, flush_ifid=1, bubble_idex=1. HALT is absorbing until rst.
  - In DRAIN/HALT: taken is forced 0, flags are frozen, and id_ld_use and ex_* inputs are ignored.
- Edge cases:
  - HLT in ID while a taken branch is in EX: the HLT is flushed and never reaches EX, so no halt.
  - ex_valid=0: no branch, no flag write, no HLT regardless of the other ex_* inputs.
  - rst asserted mid-DRAIN or in HALT returns to RUN immediately (async).
- Latency:
  - Redirect and flush: 0 cycles (same cycle as the branch in EX).
  - halted: rises DRAIN_CYCLES+1 edges after the edge on which HLT is in EX (default: 3rd edge after).

Test Plan:
- Flag write then branch: SUB with alu_z=1 and ex_set_flags=1, then B cond=001 target=16'h0040 -> flag_z=1, and in the branch cycle pc_sel=1, pc_target=0x0040, flush_ifid=1, bubble_idex=1, br_taken_cnt=1.
- Not-taken: flags N=0 Z=0, B cond=011 -> pc_sel=0, no flush, counter unchanged; then cond=101 with N=0 Z=1 -> taken.
- Load-use vs branch: id_ld_use=1 alone for 2 cycles -> stall_pc=stall_ifid=bubble_idex=1 for those 2 cycles. id_ld_use=1 with taken B cond=111 -> stall_pc=0, pc_sel=1, flush_ifid=1.
- HLT drain: HLT in EX at edge k -> stall_pc=1 from cycle k+1, halted=1 after edge k+3. Later ADD with ex_set_flags and alu_v=1 -> flag_v stays 0.
- Reset mid-operation: assert rst asynchronously during DRAIN, with flags=3'b111 and counter=5 -> immediately state RUN, halted=0, flags=0, br_taken_cnt=0.
- Saturation: force 2^CNT_W+3 taken branches (use CNT_W=4 build, 19 branches) -> br_taken_cnt holds 4'hF.

Source files
------------

// File: rtl/flow_ctrl_if.sv
// EX-stage instruction, hazard and pipeline-control signals between the core datapath and flow_ctrl.
// The datapath side is master; flow_ctrl is slave.
interface flow_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_br_cond;
    logic [PC_W-1:0]  ex_target;
    logic             ex_set_flags;
    logic             alu_n;
    logic             alu_z;
    logic             alu_v;
    logic             id_ld_use;

    logic             pc_sel;
    logic [PC_W-1:0]  pc_target;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             bubble_idex;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    logic             halted;
    logic [CNT_W-1:0] br_taken_cnt;

    modport master (
        output ex_valid, ex_opcode, ex_br_cond, ex_target, ex_set_flags,
               alu_n, alu_z, alu_v, id_ld_use,
        input  pc_sel, pc_target, stall_pc, stall_ifid, flush_ifid, bubble_idex,
               flag_n, flag_z, flag_v, halted, br_taken_cnt
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_br_cond, ex_target, ex_set_flags,
               alu_n, alu_z, alu_v, id_ld_use,
        output pc_sel, pc_target, stall_pc, stall_ifid, flush_ifid, bubble_idex,
               flag_n, flag_z, flag_v, halted, br_taken_cnt
    );
endinterface

// File: rtl/flow_ctrl.sv
// Branch resolution, N/Z/V flags, load-use stall and HLT drain for the 5-stage core; redirect/stall are 0-cycle combinational.
// No backpressure of its own: a taken branch overrides load-use stalls, and DRAIN/HALT freeze the front end.
module flow_ctrl #(
    parameter int PC_W         = 16,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    flow_ctrl_if.slave fc
);
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam int         DW     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t           state, next_state;
    logic [DW-1:0]    drain_cnt, next_drain;
    logic             flag_n_q, flag_z_q, flag_v_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cond_true;
    logic             taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain;
            // Branches never write flags, even if the decoder leaves ex_set_flags up.
            if (state == RUN && fc.ex_valid && fc.ex_set_flags && fc.ex_opcode != OP_B) begin
                flag_n_q <= fc.alu_n;
                flag_z_q <= fc.alu_z;
                flag_v_q <= fc.alu_v;
            end
            if (taken && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        cond_true      = 1'b0;
        taken          = 1'b0;
        next_state     = state;
        next_drain     = drain_cnt;
        fc.pc_sel      = 1'b0;
        fc.stall_pc    = 1'b0;
        fc.stall_ifid  = 1'b0;
        fc.flush_ifid  = 1'b0;
        fc.bubble_idex = 1'b0;
        fc.halted      = 1'b0;

        case (fc.ex_br_cond)
            3'b000:  cond_true = !flag_z_q;
            3'b001:  cond_true = flag_z_q;
            3'b010:  cond_true = !flag_z_q && !flag_n_q;
            3'b011:  cond_true = flag_n_q;
            3'b100:  cond_true = !flag_n_q;
            3'b101:  cond_true = flag_n_q || flag_z_q;
            3'b110:  cond_true = flag_v_q;
            default: cond_true = 1'b1;
        endcase

        case (state)
            RUN: begin
                taken = fc.ex_valid && fc.ex_opcode == OP_B && cond_true;
                if (taken) begin
                    fc.pc_sel      = 1'b1;
                    fc.flush_ifid  = 1'b1;
                    fc.bubble_idex = 1'b1;
                end else if (fc.id_ld_use) begin
                    fc.stall_pc    = 1'b1;
                    fc.stall_ifid  = 1'b1;
                    fc.bubble_idex = 1'b1;
                end
                if (fc.ex_valid && fc.ex_opcode == OP_HLT) begin
                    next_state = DRAIN;
                    next_drain = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                fc.stall_pc    = 1'b1;
                fc.flush_ifid  = 1'b1;
                fc.bubble_idex = 1'b1;
                if (drain_cnt == '0)
                    next_state = HALT;
                else
                    next_drain = drain_cnt - 1'b1;
            end
            default: begin
                fc.halted      = 1'b1;
                fc.stall_pc    = 1'b1;
                fc.flush_ifid  = 1'b1;
                fc.bubble_idex = 1'b1;
            end
        endcase
    end

    assign fc.pc_target    = fc.ex_target;
    assign fc.flag_n       = flag_n_q;
    assign fc.flag_z       = flag_z_q;
    assign fc.flag_v       = flag_v_q;
    assign fc.br_taken_cnt = cnt_q;
endmodule
